// File: rtl/measure_ctrl.sv
// Joystick-position measurement: counts comparator-high time over one triangle
// period, clamps and hysteresis-filters the result, and drives a display digit select.
module measure_ctrl #(
  parameter int PERIOD   = 1000,
  parameter int TICK_DIV = 10,
  parameter int WIDTH    = 7,
  parameter int MAX_VAL  = 99,
  parameter int HYST     = 1,
  parameter int DISP_DIV = 50
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             comp,
  output logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] value,
  output logic             value_stb,
  output logic             sat,
  output logic             busy,
  output logic             digit_sel
);

  localparam int SYNC_N = 2;
  localparam int WIN_W  = (PERIOD > 1)   ? $clog2(PERIOD)    : 1;
  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV)  : 1;
  localparam int ACC_W  = $clog2(MAX_VAL + 2);
  localparam int DIV_W  = (DISP_DIV > 1) ? $clog2(DISP_DIV)  : 1;

  localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(PERIOD - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [ACC_W-1:0]  ACC_MAX   = ACC_W'(MAX_VAL + 1);
  localparam logic [ACC_W-1:0]  ACC_LIM   = ACC_W'(MAX_VAL);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DISP_DIV - 1);
  localparam logic [WIDTH-1:0]  RES_MAX   = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0]  HYST_W    = WIDTH'(HYST);

  typedef enum logic [1:0] {
    IDLE,
    MEASURE,
    EVAL
  } state_t;

  state_t            state_reg;
  logic [SYNC_N-1:0] sync_reg;
  logic [WIN_W-1:0]  win_cnt_reg;
  logic [TICK_W-1:0] tick_cnt_reg;
  logic [ACC_W-1:0]  acc_reg;
  logic [WIDTH-1:0]  prev_reg;
  logic              prev_valid_reg;
  logic [WIDTH-1:0]  raw_reg;
  logic [WIDTH-1:0]  value_reg;
  logic              value_stb_reg;
  logic              sat_reg;
  logic              busy_reg;
  logic [DIV_W-1:0]  div_cnt_reg;
  logic              digit_sel_reg;

  logic              comp_sync;
  logic              acc_over;
  logic [WIDTH-1:0]  result;
  logic [WIDTH-1:0]  diff;
  logic              stable;

  assign comp_sync = sync_reg[SYNC_N-1];

  // Clamped window result and its distance from the previous window.
  always_comb begin
    acc_over = (acc_reg > ACC_LIM);
    result   = acc_over ? RES_MAX : WIDTH'(acc_reg);
    diff     = (result >= prev_reg) ? (result - prev_reg) : (prev_reg - result);
    stable   = prev_valid_reg && (diff <= HYST_W);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_N-2:0], comp};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      win_cnt_reg    <= '0;
      tick_cnt_reg   <= '0;
      acc_reg        <= '0;
      prev_reg       <= '0;
      prev_valid_reg <= 1'b0;
      raw_reg        <= '0;
      value_reg      <= '0;
      value_stb_reg  <= 1'b0;
      sat_reg        <= 1'b0;
      busy_reg       <= 1'b0;
    end else begin
      value_stb_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          // Any idle period invalidates the stored previous window.
          prev_valid_reg <= 1'b0;
          if (en) begin
            state_reg    <= MEASURE;
            win_cnt_reg  <= '0;
            tick_cnt_reg <= '0;
            acc_reg      <= '0;
            busy_reg     <= 1'b1;
          end
        end
        MEASURE: begin
          if (!en) begin
            state_reg      <= IDLE;
            busy_reg       <= 1'b0;
            prev_valid_reg <= 1'b0;
          end else begin
            if (comp_sync) begin
              if (tick_cnt_reg == TICK_LAST) begin
                tick_cnt_reg <= '0;
                if (acc_reg != ACC_MAX) begin
                  acc_reg <= acc_reg + 1'b1;
                end
              end else begin
                tick_cnt_reg <= tick_cnt_reg + 1'b1;
              end
            end
            if (win_cnt_reg == WIN_LAST) begin
              state_reg <= EVAL;
            end else begin
              win_cnt_reg <= win_cnt_reg + 1'b1;
            end
          end
        end
        EVAL: begin
          raw_reg        <= result;
          sat_reg        <= acc_over;
          prev_reg       <= result;
          prev_valid_reg <= 1'b1;
          if (stable) begin
            value_reg     <= result;
            value_stb_reg <= 1'b1;
          end
          if (en) begin
            state_reg    <= MEASURE;
            win_cnt_reg  <= '0;
            tick_cnt_reg <= '0;
            acc_reg      <= '0;
          end else begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  // Free-running display divider, deliberately independent of the FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_reg   <= '0;
      digit_sel_reg <= 1'b0;
    end else if (div_cnt_reg == DIV_LAST) begin
      div_cnt_reg   <= '0;
      digit_sel_reg <= ~digit_sel_reg;
    end else begin
      div_cnt_reg <= div_cnt_reg + 1'b1;
    end
  end

  assign raw       = raw_reg;
  assign value     = value_reg;
  assign value_stb = value_stb_reg;
  assign sat       = sat_reg;
  assign busy      = busy_reg;
  assign digit_sel = digit_sel_reg;

endmodule

// File: tb/tb_measure_ctrl.sv
// Scoreboard bench for measure_ctrl: windows are driven with hand-computed
// expected results; separate monitors check strobes and window results.
module tb_measure_ctrl;

  localparam int WIDTH = 7;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             comp;
  logic [WIDTH-1:0] raw;
  logic [WIDTH-1:0] value;
  logic             value_stb;
  logic             sat;
  logic             busy;
  logic             digit_sel;

  measure_ctrl #(
    .PERIOD(1000), .TICK_DIV(10), .WIDTH(WIDTH),
    .MAX_VAL(99), .HYST(1), .DISP_DIV(50)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .comp(comp),
    .raw(raw), .value(value), .value_stb(value_stb),
    .sat(sat), .busy(busy), .digit_sel(digit_sel)
  );

  always #5 clk = ~clk;

  typedef struct {
    int due;
    int raw;
    bit sat;
    int value;
  } win_exp_t;

  int       errors = 0;
  int       checks = 0;
  int       cyc = 0;
  int       stb_q[$];
  win_exp_t win_q[$];
  win_exp_t wchk;
  int       stb_exp;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Strobe monitor: every value_stb pulse must match the next queued value.
  initial begin
    forever begin
      @(negedge clk);
      if (value_stb !== 1'b0) begin
        if (stb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_strobe: got value_stb=1 value=%0d, expected no strobe", value);
        end else begin
          stb_exp = stb_q.pop_front();
          $display("strobe value=%0d expected=%0d", value, stb_exp);
          check("strobe_value", int'(value), stb_exp);
        end
      end
    end
  end

  // Window monitor: checks raw/sat/value on the cycle after each EVAL.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (win_q.size() > 0 && win_q[0].due == cyc) begin
        wchk = win_q.pop_front();
        $display("window raw=%0d sat=%0d value=%0d (expected %0d/%0d/%0d)",
                 raw, sat, value, wchk.raw, wchk.sat, wchk.value);
        check("win_raw", int'(raw), wchk.raw);
        check("win_sat", int'(sat), int'(wchk.sat));
        check("win_value", int'(value), wchk.value);
      end
    end
  end

  // Drives one window; iteration i sets the comp value the DUT consumes in
  // window cycle i (two-flop synchronizer latency absorbed by starting early).
  task automatic drive_window(input int hs, input int he, input int abort_at,
                              input bit chk, input int e_raw, input bit e_sat,
                              input int e_val, input bit e_stb);
    win_exp_t w;
    if (e_stb) stb_q.push_back(e_val);
    for (int i = 0; i <= 1000; i++) begin
      comp = (i < hs) || (i >= 1000 - he && i < 1000);
      if (i == 1) en = 1'b1;
      if (abort_at >= 0 && i == abort_at + 2) begin
        en   = 1'b0;
        comp = 1'b0;
        @(posedge clk);
        #1;
        $display("abort busy=%0d raw=%0d value=%0d sat=%0d", busy, raw, value, sat);
        check("abort_busy", int'(busy), 0);
        check("abort_raw", int'(raw), e_raw);
        check("abort_value", int'(value), e_val);
        check("abort_sat", int'(sat), int'(e_sat));
        return;
      end
      if (i == 1000 && chk) begin
        w.due   = cyc + 3;
        w.raw   = e_raw;
        w.sat   = e_sat;
        w.value = e_val;
        win_q.push_back(w);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic stop_en();
    @(posedge clk);
    #1;
    en   = 1'b0;
    comp = 1'b0;
  endtask

  int dsel_n[6] = '{49, 50, 99, 100, 149, 150};
  int dsel_e[6] = '{0, 1, 1, 0, 0, 1};

  initial begin
    rst  = 1'b1;
    en   = 1'b1;
    comp = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_raw", int'(raw), 0);
    check("rst_value", int'(value), 0);
    check("rst_stb", int'(value_stb), 0);
    check("rst_sat", int'(sat), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_digit_sel", int'(digit_sel), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("busy_after_release", int'(busy), 1);
    en   = 1'b0;
    comp = 1'b0;
    @(posedge clk);
    #1;
    check("busy_after_disable", int'(busy), 0);
    repeat (4) @(posedge clk);
    #1;

    // Stable mid value
    drive_window(250, 250, -1, 1, 50, 0, 0, 0);
    drive_window(250, 250, -1, 1, 50, 0, 50, 1);
    drive_window(255, 255, -1, 1, 51, 0, 51, 1);
    stop_en();
    // Hysteresis: re-enable clears prev, diff 2 rejected, 50 -> 90 needs two windows
    drive_window(500, 0, -1, 1, 50, 0, 51, 0);
    drive_window(500, 0, -1, 1, 50, 0, 50, 1);
    drive_window(260, 260, -1, 1, 52, 0, 50, 0);
    drive_window(900, 0, -1, 1, 90, 0, 50, 0);
    drive_window(900, 0, -1, 1, 90, 0, 90, 1);
    // Abort at window cycle 300, then re-enable with an identical result
    drive_window(900, 0, 300, 1, 90, 0, 90, 0);
    drive_window(900, 0, -1, 1, 90, 0, 90, 0);
    // Saturation then zero windows
    drive_window(1000, 0, -1, 1, 99, 1, 90, 0);
    drive_window(1000, 0, -1, 1, 99, 1, 99, 1);
    drive_window(0, 0, -1, 1, 0, 0, 99, 0);
    drive_window(0, 0, -1, 1, 0, 0, 0, 1);
    drive_window(1000, 0, -1, 1, 99, 1, 0, 0);
    // Reset asserted while in EVAL of a window that would otherwise strobe 99
    drive_window(1000, 0, -1, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    en  = 1'b0;
    comp = 1'b0;
    @(posedge clk);
    #1;
    $display("eval_reset raw=%0d value=%0d sat=%0d busy=%0d stb=%0d", raw, value, sat, busy, value_stb);
    check("eval_rst_raw", int'(raw), 0);
    check("eval_rst_value", int'(value), 0);
    check("eval_rst_sat", int'(sat), 0);
    check("eval_rst_busy", int'(busy), 0);
    check("eval_rst_stb", int'(value_stb), 0);
    check("eval_rst_digit_sel", int'(digit_sel), 0);
    rst = 1'b0;

    // Display divider, with en toggled in the middle
    for (int n = 1; n <= 150; n++) begin
      if (n == 20) en = 1'b1;
      if (n == 120) en = 1'b0;
      @(posedge clk);
      #1;
      for (int k = 0; k < 6; k++) begin
        if (dsel_n[k] == n) begin
          $display("digit_sel cycle=%0d value=%0d", n, digit_sel);
          check($sformatf("digit_sel_c%0d", n), int'(digit_sel), dsel_e[k]);
        end
      end
    end

    repeat (5) @(posedge clk);
    #1;
    check("strobe_queue_drained", stb_q.size(), 0);
    check("window_queue_drained", win_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
